rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Shares the register file's single write port (we3/addr3/write3) between two writeback requesters.
//   - Port 0: ALU result.
//   - Port 1: load (memory) result.
//   Arbitrates with valid/ready handshakes and registers the winning write before it reaches the register file.
//   Answers hazard queries from decode: "is a write to this register still in flight?"
//   Sits between the EX/MEM writeback paths and the register file.
// PARAMETERS
//   AW     5    register address width
//   DW     32   register data width
//   ZREG   31   hardwired-zero register index; writes to it are discarded
// PORTS
//   clk        in   1    clock, rising edge
//   reset_n    in   1    asynchronous reset, active low
//   v0         in   1    port 0 (ALU) write request valid
//   a0         in   AW   port 0 destination register
//   d0         in   DW   port 0 write data
//   rdy0       out  1    port 0 request accepted this cycle
//   v1         in   1    port 1 (load) write request valid
//   a1         in   AW   port 1 destination register
//   d1         in   DW   port 1 write data
//   rdy1       out  1    port 1 request accepted this cycle
//   rf_we      out  1    to register file we3
//   rf_addr    out  AW   to register file addr3
//   rf_wdata   out  DW   to register file write3
//   qaddr1     in   AW   hazard query address 1 (decode rs)
//   qbusy1     out  1    write pending for qaddr1
//   qaddr2     in   AW   hazard query address 2 (decode rt)
//   qbusy2     out  1    write pending for qaddr2
// BEHAVIOUR
//   Reset:
//   - Async, active low; takes effect immediately.
//   - rf_we=0, rf_addr=0, rf_wdata=0, last_grant=1, so port 0 wins the first contested cycle.
//   Grant (combinational):
//   - At most one of rdy0/rdy1 is high per cycle.
//   - rdyN=1 only when vN=1 and port N wins.
//   - A transfer occurs when vN && rdyN.
//   - A requester holds vN/aN/dN stable until it sees rdyN.
//   Arbitration:
//   - Single requester always wins.
//   - Contention is resolved per CONFIGURATION.
//   - last_grant updates only on a contested grant.
//   Output stage, 1-cycle latency:
//   - A transfer in cycle T with aN!=ZREG drives rf_we=1, rf_addr=aN, rf_wdata=dN in cycle T+1.
//   - With no transfer, rf_we=0 in T+1; rf_addr/rf_wdata hold their last values.
//   - The register file always accepts, so the stage never stalls: back-to-back transfers give rf_we=1 every cycle.
//   Zero register:
//   - A request with aN==ZREG is handshaken normally (rdyN=1), but rf_we stays 0 in T+1.
//   Same destination on both ports:
//   - Both writes are performed, in grant order; the later grant's data is the final value.
//   Hazard query (combinational):
//   - qbusyK = (qaddrK!=ZREG) && ( (rf_we && rf_addr==qaddrK) || (v0 && a0==qaddrK) || (v1 && a1==qaddrK) ).
//   Reset mid-operation:
//   - A pending registered write is dropped (rf_we forced 0).
//   - Un-handshaken requests are not remembered.
// CONFIGURATION
//   WB_ROUND_ROBIN_EN defined:
//   - Round-robin on contention: the port not in last_grant wins.
//   - Under continuous contention, grants alternate 0,1,0,1,...
//   WB_ROUND_ROBIN_EN undefined:
//   - Fixed priority: port 1 (load) always wins on contention; last_grant is unused.
//   - Port 0 may starve while v1 is held high.
// TESTING
//   1. Single write: v0=1, a0=5, d0=32'hDEADBEEF for one cycle
//      -> rdy0=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=32'hDEADBEEF; cycle after, rf_we=0.
//   2. Contention, macro defined: v0=v1=1 for 4 cycles from reset (a0=1, a1=2)
//      -> grants 0,1,0,1; rf_addr sequence 1,2,1,2.
//   3. Contention, macro undefined: same stimulus
//      -> rdy1=1 and rdy0=0 every cycle; rf_addr=2 each cycle.
//   4. Zero register: v1=1, a1=31, d1=32'h12345678
//      -> rdy1=1; rf_we stays 0 in the next cycle.
//   5. Hazard query: v1=1, a1=7, qaddr1=7, qaddr2=31
//      -> qbusy1=1, qbusy2=0; one cycle after grant (rf_we=1, rf_addr=7, v1=0) -> qbusy1 still 1; following cycle -> 0.
//   6. Reset mid-write: drop reset_n while rf_we=1
//      -> rf_we=0, rf_addr=0, rf_wdata=0 immediately, before the next clk edge; first contested grant after release goes to port 0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Writeback bundle between the two requesters, decode's hazard queries and the register-file write port.
// The arbiter takes the slave view, the environment drives the master view.
interface rf_write_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          rdy0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          rdy1;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] qaddr1;
    logic          qbusy1;
    logic [AW-1:0] qaddr2;
    logic          qbusy2;

    modport master (
        output v0, a0, d0, v1, a1, d1, qaddr1, qaddr2,
        input  rdy0, rdy1, rf_we, rf_addr, rf_wdata, qbusy1, qbusy2
    );

    modport slave (
        input  v0, a0, d0, v1, a1, d1, qaddr1, qaddr2,
        output rdy0, rdy1, rf_we, rf_addr, rf_wdata, qbusy1, qbusy2
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU (port 0) and load (port 1) writeback paths.
// Define WB_ROUND_ROBIN_EN for round-robin contention; otherwise the load port has fixed priority.
module rf_write_arbiter #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int ZREG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    rf_write_arbiter_if.slave wb
);
    localparam logic [AW-1:0] ZADDR = AW'(ZREG);

    logic          grant1;
    logic          xfer;
    logic          xfer_write;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_data;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

`ifdef WB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the port that did not win the previous contested cycle goes next.
    assign grant1 = wb.v1 && (!wb.v0 || !last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (wb.v0 && wb.v1) begin
            last_grant <= grant1;
        end
    end
`else
    assign grant1 = wb.v1;
`endif

    assign wb.rdy0    = wb.v0 && !grant1;
    assign wb.rdy1    = grant1;
    assign xfer       = wb.rdy0 || wb.rdy1;
    assign xfer_addr  = grant1 ? wb.a1 : wb.a0;
    assign xfer_data  = grant1 ? wb.d1 : wb.d0;
    assign xfer_write = xfer && (xfer_addr != ZADDR);

    // Zero-register transfers complete the handshake but never reach the register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= xfer_write;
            if (xfer_write) begin
                addr_q <= xfer_addr;
                data_q <= xfer_data;
            end
        end
    end

    assign wb.rf_we    = we_q;
    assign wb.rf_addr  = addr_q;
    assign wb.rf_wdata = data_q;

    // A register is busy while a request targets it or its registered write has not landed yet.
    assign wb.qbusy1 = (wb.qaddr1 != ZADDR) &&
                       ((we_q && addr_q == wb.qaddr1) ||
                        (wb.v0 && wb.a0 == wb.qaddr1) ||
                        (wb.v1 && wb.a1 == wb.qaddr1));
    assign wb.qbusy2 = (wb.qaddr2 != ZADDR) &&
                       ((we_q && addr_q == wb.qaddr2) ||
                        (wb.v0 && wb.a0 == wb.qaddr2) ||
                        (wb.v1 && wb.a1 == wb.qaddr2));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter with a behavioural model checked every cycle, plus directed scenarios.
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   nChecks = 0;
    int   nPass = 0;

    rf_write_arbiter_if #(.AW(5), .DW(32)) bus ();

    rf_write_arbiter #(.AW(5), .DW(32), .ZREG(31)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: the committed register-file output plus the last contested winner.
    bit          mWe = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    bit          mKnown = 1'b1;
    int          mLast = 1;
    bit          g0 = 1'b0;
    bit          g1 = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] q1, input logic [4:0] q2);
        bus.v0 = v0; bus.a0 = a0; bus.d0 = d0;
        bus.v1 = v1; bus.a1 = a1; bus.d1 = d1;
        bus.qaddr1 = q1; bus.qaddr2 = q2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit expBusy(input logic [4:0] q);
        return (q != 5'd31) && ((mWe && mAddr == q) || (bus.v0 && bus.a0 == q) || (bus.v1 && bus.a1 == q));
    endfunction

    function automatic logic [4:0] randAddr();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    // Compare process: check at the falling edge, commit the model at the rising edge.
    initial begin
        int          w;
        bit          nWe;
        logic [4:0]  nAddr;
        logic [31:0] nData;
        bit          nKnown;
        int          nLast;
        #2;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mWe = 0; mAddr = '0; mData = '0; mKnown = 1; mLast = 1;
                g0 = 0; g1 = 0;
                checkOutput("reset rf_we", 32'(bus.rf_we), 32'd0);
                checkOutput("reset rf_addr", 32'(bus.rf_addr), 32'd0);
                checkOutput("reset rf_wdata", bus.rf_wdata, 32'd0);
                nWe = 0; nAddr = '0; nData = '0; nKnown = 1; nLast = 1;
            end else begin
                if (bus.v0 && bus.v1) begin
`ifdef WB_ROUND_ROBIN_EN
                    w = (mLast == 0) ? 1 : 0;
`else
                    w = 1;
`endif
                end else if (bus.v0) w = 0;
                else if (bus.v1) w = 1;
                else w = -1;
                g0 = (w == 0);
                g1 = (w == 1);
                checkOutput("model rdy0", 32'(bus.rdy0), 32'(g0));
                checkOutput("model rdy1", 32'(bus.rdy1), 32'(g1));
                checkOutput("model rf_we", 32'(bus.rf_we), 32'(mWe));
                if (mKnown) begin
                    checkOutput("model rf_addr", 32'(bus.rf_addr), 32'(mAddr));
                    checkOutput("model rf_wdata", bus.rf_wdata, mData);
                end
                checkOutput("model qbusy1", 32'(bus.qbusy1), 32'(expBusy(bus.qaddr1)));
                checkOutput("model qbusy2", 32'(bus.qbusy2), 32'(expBusy(bus.qaddr2)));
                nLast = (bus.v0 && bus.v1) ? w : mLast;
                nWe = 0; nAddr = mAddr; nData = mData; nKnown = mKnown;
                if (w >= 0) begin
                    nAddr = (w == 0) ? bus.a0 : bus.a1;
                    nData = (w == 0) ? bus.d0 : bus.d1;
                    if (nAddr != 5'd31) begin
                        nWe = 1; nKnown = 1;
                    end else begin
                        nAddr = mAddr; nData = mData; nKnown = 0;
                    end
                end
            end
            @(posedge clk);
            if (reset_n) begin
                mWe = nWe; mAddr = nAddr; mData = nData; mKnown = nKnown; mLast = nLast;
            end
        end
    end

    initial begin
        int expGrant [4];
        int expAddr [4];
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("reset state rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("reset state rf_addr", 32'(bus.rf_addr), 32'd0);
        checkOutput("reset state rf_wdata", bus.rf_wdata, 32'd0);
        reset_n = 1'b1;

`ifdef WB_ROUND_ROBIN_EN
        expGrant = '{0, 1, 0, 1};
        expAddr  = '{1, 2, 1, 2};
`else
        expGrant = '{1, 1, 1, 1};
        expAddr  = '{2, 2, 2, 2};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i < 4) applyStimulus(1, 5'd1, 32'hA0, 1, 5'd2, 32'hB1, 0, 0);
            else applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (i < 4) begin
                checkOutput("contention rdy0", 32'(bus.rdy0), 32'(expGrant[i] == 0));
                checkOutput("contention rdy1", 32'(bus.rdy1), 32'(expGrant[i] == 1));
            end
            if (i > 0) begin
                checkOutput("contention rf_we", 32'(bus.rf_we), 32'd1);
                checkOutput("contention rf_addr", 32'(bus.rf_addr), 32'(expAddr[i-1]));
            end
            nextCycle();
        end

        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        #1 checkOutput("single rdy0", 32'(bus.rdy0), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("single rf_we", 32'(bus.rf_we), 32'd1);
        checkOutput("single rf_addr", 32'(bus.rf_addr), 32'd5);
        checkOutput("single rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        nextCycle();
        checkOutput("single rf_we idle", 32'(bus.rf_we), 32'd0);
        checkOutput("single rf_addr hold", 32'(bus.rf_addr), 32'd5);

        applyStimulus(0, 0, 0, 1, 5'd31, 32'h12345678, 0, 0);
        #1 checkOutput("zreg rdy1", 32'(bus.rdy1), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("zreg rf_we", 32'(bus.rf_we), 32'd0);
        nextCycle();

        applyStimulus(0, 0, 0, 1, 5'd7, 32'h55, 5'd7, 5'd31);
        #1 checkOutput("hazard qbusy1 req", 32'(bus.qbusy1), 32'd1);
        checkOutput("hazard qbusy2 zreg", 32'(bus.qbusy2), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd31);
        #1 checkOutput("hazard rf_addr", 32'(bus.rf_addr), 32'd7);
        checkOutput("hazard qbusy1 inflight", 32'(bus.qbusy1), 32'd1);
        nextCycle();
        checkOutput("hazard qbusy1 done", 32'(bus.qbusy1), 32'd0);

        applyStimulus(1, 5'd9, 32'h77, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("midreset rf_we before", 32'(bus.rf_we), 32'd1);
        #1 reset_n = 1'b0;
        #1 checkOutput("midreset rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("midreset rf_addr", 32'(bus.rf_addr), 32'd0);
        checkOutput("midreset rf_wdata", bus.rf_wdata, 32'd0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0);
`ifdef WB_ROUND_ROBIN_EN
        #1 checkOutput("post-reset rdy0", 32'(bus.rdy0), 32'd1);
`else
        #1 checkOutput("post-reset rdy0", 32'(bus.rdy0), 32'd0);
`endif
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Requesters hold their request until the model says it was granted.
        for (int i = 0; i < 400; i++) begin
            if (!(bus.v0 && !g0)) begin
                bus.v0 = ($urandom_range(0, 9) < 6);
                bus.a0 = randAddr();
                bus.d0 = $urandom;
            end
            if (!(bus.v1 && !g1)) begin
                bus.v1 = ($urandom_range(0, 9) < 6);
                bus.a1 = randAddr();
                bus.d1 = $urandom;
            end
            bus.qaddr1 = randAddr();
            bus.qaddr2 = randAddr();
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
